// File: rtl/thumb_fetch_unit_pkg.sv
// Shared types and constants for the Thumb fetch front end.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package thumb_fetch_unit_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } fetch_state_t;

    localparam int          HW_W      = 16;
    localparam logic [31:0] WORD_STEP = 32'd4;
    localparam logic [31:0] HW_STEP   = 32'd2;

    // One prefetch queue entry: halfword plus the address it came from
    typedef struct packed {
        logic [31:0]     pc;
        logic [HW_W-1:0] hw;
    } hw_entry_t;

endpackage

// File: rtl/fetch_hw_fifo.sv
// Circular prefetch queue of {pc, halfword} entries with dual push, pop and clear.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: none internally; the caller guarantees space before pushing.
//
// Ports: push0 is written ahead of push1 when both are valid in the same cycle;
// clear empties the queue and wins over any same-cycle push; count is 0..DEPTH.
module fetch_hw_fifo
    import thumb_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        push0_vld,
    input  hw_entry_t   push0_dat,
    input  logic        push1_vld,
    input  hw_entry_t   push1_dat,
    input  logic        pop_vld,
    input  logic        clear,
    output logic [AW:0] count,
    output hw_entry_t   head_dat
);

    hw_entry_t       mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [AW-1:0]   slot1;
    logic [AW:0]     n_push;

    assign n_push   = (AW+1)'(push0_vld) + (AW+1)'(push1_vld);
    // push1 lands right behind push0 when both are present
    assign slot1    = tail + AW'(push0_vld);
    assign head_dat = mem[head];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + AW'(n_push);
            head  <= head + AW'(pop_vld);
            count <= count + n_push - (AW+1)'(pop_vld);
        end
    end

    // Storage needs no reset: entries are only observed while count is non-zero
    always_ff @(posedge CLK) begin
        if (!clear) begin
            if (push0_vld) mem[tail]  <= push0_dat;
            if (push1_vld) mem[slot1] <= push1_dat;
        end
    end

endmodule

// File: rtl/thumb_fetch_unit.sv
// Thumb fetch front end: 32-bit memory fetches split into halfwords for IF.
// Latency: IREQ rises in cycle 0, first halfword valid on INST in cycle MEM_LAT+1.
// Backpressure: INST_VALID/INST_READY; fetch stalls until 2 queue slots are free.
//
// Ports: CLK/RESET_N; IREQ/IADDR/IRW/INSTR memory side; BR_TAKEN/BR_TARGET redirect;
// INST_VALID/INST_READY/INST/INST_PC towards IF; FLUSHING marks a discarded in-flight fetch.
module thumb_fetch_unit
    import thumb_fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MEM_LAT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            CLK,
    input  logic            RESET_N,
    output logic            IREQ,
    output logic [31:0]     IADDR,
    output logic            IRW,
    input  logic [31:0]     INSTR,
    input  logic            BR_TAKEN,
    input  logic [31:0]     BR_TARGET,
    output logic            INST_VALID,
    input  logic            INST_READY,
    output logic [HW_W-1:0] INST,
    output logic [31:0]     INST_PC,
    output logic            FLUSHING
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    fetch_state_t  state;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   fetch_pc;
    logic          skip_lo;
    logic          discard;

    // Word sampled at the end of the memory window, pushed during GAP
    logic          cap_vld;
    logic          cap_skip;
    logic [31:0]   cap_pc;
    logic [31:0]   cap_data;
    logic [1:0]    cap_n;

    logic [AW:0]   q_count;
    hw_entry_t     q_head;
    hw_entry_t     last_dat;
    hw_entry_t     push0_dat;
    hw_entry_t     push1_dat;
    logic          pop;
    logic          can_issue;

    assign IRW        = 1'b0;
    assign FLUSHING   = discard;
    assign INST_VALID = (q_count != '0);
    assign pop        = INST_VALID && INST_READY;

    // Output holds the most recently delivered entry while the queue is empty
    assign INST    = INST_VALID ? q_head.hw : last_dat.hw;
    assign INST_PC = INST_VALID ? q_head.pc : last_dat.pc;

    // The pending capture already owns queue slots, so it is counted as occupied
    assign cap_n     = cap_vld ? (cap_skip ? 2'd1 : 2'd2) : 2'd0;
    assign can_issue = !BR_TAKEN && (int'(q_count) + int'(cap_n) + 2 <= DEPTH);

    assign push0_dat = {cap_pc, cap_data[15:0]};
    assign push1_dat = {cap_pc + HW_STEP, cap_data[31:16]};

    fetch_hw_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .push0_vld (cap_vld && !cap_skip),
        .push0_dat (push0_dat),
        .push1_vld (cap_vld),
        .push1_dat (push1_dat),
        .pop_vld   (pop),
        .clear     (BR_TAKEN),
        .count     (q_count),
        .head_dat  (q_head)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            last_dat <= '0;
        end else if (pop) begin
            last_dat <= q_head;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            IREQ     <= 1'b0;
            IADDR    <= RESET_PC & ~32'h3;
            wait_cnt <= '0;
            fetch_pc <= RESET_PC;
            skip_lo  <= RESET_PC[1];
            discard  <= 1'b0;
            cap_vld  <= 1'b0;
            cap_skip <= 1'b0;
            cap_pc   <= '0;
            cap_data <= '0;
        end else begin
            cap_vld <= 1'b0;
            case (state)
                // GAP is the mandatory dead cycle; it also makes the issue decision
                // so back-to-back fetches run at one request per MEM_LAT+1 cycles
                ST_IDLE, ST_GAP: begin
                    if (can_issue) begin
                        state    <= ST_REQ;
                        IREQ     <= 1'b1;
                        IADDR    <= fetch_pc & ~32'h3;
                        wait_cnt <= CW'(MEM_LAT - 1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (wait_cnt == '0) begin
                        state   <= ST_GAP;
                        IREQ    <= 1'b0;
                        discard <= 1'b0;
                        // Data for a redirected request is dropped on this edge
                        if (!discard && !BR_TAKEN) begin
                            cap_vld  <= 1'b1;
                            cap_skip <= skip_lo;
                            cap_pc   <= IADDR;
                            cap_data <= INSTR;
                            fetch_pc <= IADDR + WORD_STEP;
                            skip_lo  <= 1'b0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                        if (BR_TAKEN) discard <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    IREQ  <= 1'b0;
                end
            endcase
            // A redirect always owns the next fetch address, even mid-discard
            if (BR_TAKEN) begin
                fetch_pc <= BR_TARGET & ~32'h1;
                skip_lo  <= BR_TARGET[1];
            end
        end
    end

endmodule

// File: tb/tb_thumb_fetch_unit.sv
// Scoreboard bench for thumb_fetch_unit with a fixed-latency memory model.
module tb_thumb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        IREQ;
    logic [31:0] IADDR;
    logic        IRW;
    logic [31:0] INSTR;
    logic        BR_TAKEN;
    logic [31:0] BR_TARGET;
    logic        INST_VALID;
    logic        INST_READY;
    logic [15:0] INST;
    logic [31:0] INST_PC;
    logic        FLUSHING;

    int checks   = 0;
    int failures = 0;

    logic [47:0] exp_q[$];

    always #5 CLK = ~CLK;

    thumb_fetch_unit #(
        .DEPTH    (4),
        .MEM_LAT  (2),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .IREQ       (IREQ),
        .IADDR      (IADDR),
        .IRW        (IRW),
        .INSTR      (INSTR),
        .BR_TAKEN   (BR_TAKEN),
        .BR_TARGET  (BR_TARGET),
        .INST_VALID (INST_VALID),
        .INST_READY (INST_READY),
        .INST       (INST),
        .INST_PC    (INST_PC),
        .FLUSHING   (FLUSHING)
    );

    // Memory contents: two hand-picked words, every other word derived from its address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [15:0] lo;
        case (a)
            32'h0000_0000: return 32'hBBBB_AAAA;
            32'h0000_0004: return 32'hDDDD_CCCC;
            default: begin
                lo = a[15:0];
                return {(lo + 16'd2) ^ 16'h5A5A, lo ^ 16'h5A5A};
            end
        endcase
    endfunction

    function automatic logic [15:0] exp_hw(input logic [31:0] pc);
        logic [15:0] lo;
        case (pc)
            32'h0000_0000: return 16'hAAAA;
            32'h0000_0002: return 16'hBBBB;
            32'h0000_0004: return 16'hCCCC;
            32'h0000_0006: return 16'hDDDD;
            default: begin
                lo = pc[15:0];
                return lo ^ 16'h5A5A;
            end
        endcase
    endfunction

    always_comb INSTR = mem_word(IADDR);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected delivery order after a (re)start at pc: sequential halfwords
    task automatic push_stream(input logic [31:0] start, input int n);
        logic [31:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = start + 32'(2 * i);
            exp_q.push_back({pc, exp_hw(pc)});
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ireq_rise(input string name);
        logic prev;
        logic seen;
        prev = IREQ;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            cyc();
            if (IREQ && !prev) seen = 1'b1;
            prev = IREQ;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    // Monitor: every accepted halfword is compared against the scoreboard head
    always @(negedge CLK) begin
        logic [47:0] e;
        if (RESET_N && INST_VALID && INST_READY) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got pc %h inst %h, expected nothing", INST_PC, INST);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", INST_PC, e[47:16]);
                chk("pop_inst", 32'(INST), 32'(e[15:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rises;
        logic [31:0] first_addr;
        logic saw_req;

        // ---- Reset values and first-fetch timing ----
        RESET_N    = 1'b0;
        INST_READY = 1'b1;
        BR_TAKEN   = 1'b0;
        BR_TARGET  = 32'h0;
        repeat (3) cyc();
        chk("rst_ireq", 32'(IREQ), 32'd0);
        chk("rst_iaddr", IADDR, 32'h0);
        chk("rst_valid", 32'(INST_VALID), 32'd0);
        chk("rst_inst", 32'(INST), 32'h0);
        chk("rst_pc", INST_PC, 32'h0);
        chk("rst_flush", 32'(FLUSHING), 32'd0);
        chk("rst_irw", 32'(IRW), 32'd0);
        push_stream(32'h0, 64);
        RESET_N = 1'b1;
        cyc();
        chk("c0_ireq", 32'(IREQ), 32'd1);
        chk("c0_iaddr", IADDR, 32'h0);
        cyc();
        chk("c1_ireq", 32'(IREQ), 32'd1);
        chk("c1_valid", 32'(INST_VALID), 32'd0);
        cyc();
        chk("c2_ireq", 32'(IREQ), 32'd0);
        cyc();
        chk("c3_valid", 32'(INST_VALID), 32'd1);
        chk("c3_inst", 32'(INST), 32'hAAAA);
        chk("c3_pc", INST_PC, 32'h0);
        chk("c3_iaddr", IADDR, 32'h4);
        repeat (20) cyc();

        // ---- Async reset in the middle of a request ----
        wait_ireq_rise("rise_before_reset");
        RESET_N = 1'b0;
        #1;
        chk("arst_ireq", 32'(IREQ), 32'd0);
        chk("arst_valid", 32'(INST_VALID), 32'd0);
        exp_q.delete();

        // ---- Consumer stalled: exactly two words fetched, then refill on 2 free slots ----
        INST_READY = 1'b0;
        repeat (2) cyc();
        push_stream(32'h0, 64);
        RESET_N = 1'b1;
        rises = 0;
        first_addr = 32'hFFFF_FFFF;
        saw_req = 1'b0;
        for (int i = 0; i < 30; i++) begin
            saw_req = IREQ;
            cyc();
            if (IREQ && !saw_req) begin
                rises++;
                if (rises == 1) first_addr = IADDR;
            end
        end
        chk("stall_fetches", 32'(rises), 32'd2);
        chk("restart_addr", first_addr, 32'h0);
        chk("stall_valid", 32'(INST_VALID), 32'd1);
        chk("stall_inst", 32'(INST), 32'hAAAA);
        INST_READY = 1'b1;
        cyc();
        INST_READY = 1'b0;
        saw_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (IREQ) saw_req = 1'b1;
        end
        chk("one_free_no_req", 32'(saw_req), 32'd0);
        INST_READY = 1'b1;
        cyc();
        INST_READY = 1'b0;
        cyc();
        chk("two_free_req", 32'(IREQ), 32'd1);
        chk("two_free_addr", IADDR, 32'h8);
        INST_READY = 1'b1;
        repeat (15) cyc();

        // ---- Redirect together with a pop and a pending capture push ----
        RESET_N    = 1'b0;
        INST_READY = 1'b0;
        repeat (2) cyc();
        exp_q.delete();
        push_stream(32'h0, 64);
        RESET_N = 1'b1;
        repeat (6) cyc();
        chk("gap_ireq", 32'(IREQ), 32'd0);
        chk("gap_valid", 32'(INST_VALID), 32'd1);
        chk("gap_inst", 32'(INST), 32'hAAAA);
        INST_READY = 1'b1;
        BR_TAKEN   = 1'b1;
        BR_TARGET  = 32'h0000_0200;
        cyc();
        exp_q.delete();
        push_stream(32'h200, 64);
        BR_TAKEN = 1'b0;
        chk("br_pop_empty", 32'(INST_VALID), 32'd0);
        chk("br_no_issue", 32'(IREQ), 32'd0);
        cyc();
        chk("br_req", 32'(IREQ), 32'd1);
        chk("br_addr", IADDR, 32'h200);
        repeat (12) cyc();

        // ---- Redirect during REQ to an unaligned target ----
        wait_ireq_rise("rise_before_redirect");
        BR_TAKEN  = 1'b1;
        BR_TARGET = 32'h0000_0103;
        cyc();
        exp_q.delete();
        push_stream(32'h102, 64);
        BR_TAKEN = 1'b0;
        chk("flush_hi", 32'(FLUSHING), 32'd1);
        chk("flush_ireq_held", 32'(IREQ), 32'd1);
        chk("flush_q_empty", 32'(INST_VALID), 32'd0);
        cyc();
        chk("flush_lo", 32'(FLUSHING), 32'd0);
        chk("flush_gap_ireq", 32'(IREQ), 32'd0);
        chk("flush_discarded", 32'(INST_VALID), 32'd0);
        cyc();
        chk("redir_req", 32'(IREQ), 32'd1);
        chk("redir_addr", IADDR, 32'h100);
        repeat (12) cyc();

        // ---- Fetch address wrap at the top of the address space ----
        BR_TAKEN  = 1'b1;
        BR_TARGET = 32'hFFFF_FFFC;
        cyc();
        exp_q.delete();
        push_stream(32'hFFFF_FFFC, 64);
        BR_TAKEN = 1'b0;
        wait_ireq_rise("rise_wrap_top");
        chk("wrap_top_addr", IADDR, 32'hFFFF_FFFC);
        wait_ireq_rise("rise_wrap_zero");
        chk("wrap_zero_addr", IADDR, 32'h0);
        repeat (12) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/thumb_fetch_unit.md
Name: thumb_fetch_unit

Overview:
Instruction-fetch front end that sits directly upstream of the Thumb core's IF stage. It fetches 32-bit words from instruction memory and splits each word into two 16-bit Thumb halfwords. The halfwords go into a small prefetch queue and are handed to IF with their PCs over a valid/ready handshake. On a taken branch it flushes the queue and restarts fetch at the target.

Parameters:
DEPTH, 4, prefetch queue depth in halfwords; power of 2, minimum 2
MEM_LAT, 2, cycles IREQ is held per request; INSTR is sampled on the last edge of that window; minimum 1
RESET_PC, 32'h0000_0000, first fetch address after reset; halfword aligned

Ports:
CLK  in  1  clock, all state on rising edge
RESET_N  in  1  reset, asynchronous, active-low
IREQ  out  1  instruction memory request
IADDR  out  32  word-aligned fetch address; [1:0] always 0
IRW  out  1  constant 0 (read)
INSTR  in  32  memory read data; [15:0] is the lower halfword
BR_TAKEN  in  1  redirect strobe from ID/EX
BR_TARGET  in  32  redirect PC; bit0 ignored
INST_VALID  out  1  INST and INST_PC are valid
INST_READY  in  1  IF accepts; a pop occurs when INST_VALID and INST_READY
INST  out  16  Thumb halfword at the queue head
INST_PC  out  32  address of INST
FLUSHING  out  1  high while an in-flight fetch is being discarded

Behaviour:
- Reset (async assert, sync release):
  - IREQ=0, IADDR=RESET_PC&~3, queue empty, INST_VALID=0, INST=0, INST_PC=0, FLUSHING=0.
  - fetch_pc=RESET_PC, skip_lo=RESET_PC[1].
- FSM states:
  - IDLE: if BR_TAKEN=0 and free slots (DEPTH-count, registered) >= 2, go to REQ. IREQ=1, IADDR=fetch_pc&~3, wait counter=MEM_LAT-1.
  - REQ: IREQ held high. The counter decrements each cycle. On the edge where the counter reaches 0, INSTR is sampled and the FSM goes to GAP with IREQ=0.
  - GAP: one mandatory idle cycle with IREQ=0, then IDLE.
- Capture (no discard pending):
  - Push INSTR[15:0] at PC fetch_pc&~3 unless skip_lo.
  - Push INSTR[31:16] at PC (fetch_pc&~3)+2.
  - Then fetch_pc=(fetch_pc&~3)+4 (wraps modulo 2^32) and skip_lo=0.
- Latency: IREQ rises in cycle 0; the halfword is visible on INST with INST_VALID=1 in cycle MEM_LAT+1.
- Throughput: 2 halfwords per MEM_LAT+1 cycles.
- Queue:
  - Circular buffer with head/tail pointers and a count in 0..DEPTH.
  - Push and pop in the same cycle are both honoured.
  - A push never overflows, because issue requires 2 free slots at request time and pops only add space.
  - Empty: INST_VALID=0. INST/INST_PC hold their last values.
- Redirect (BR_TAKEN=1):
  - Queue is cleared next edge; any same-cycle pop is considered delivered; any same-cycle push is dropped.
  - fetch_pc=BR_TARGET&~1, skip_lo=BR_TARGET[1].
  - If the FSM is in REQ: IREQ stays high until the window completes (memory requests are never aborted). The returned data is discarded and FLUSHING=1 from the cycle after BR_TAKEN until the discard edge.
  - A new request to the target issues after GAP.
  - A second BR_TAKEN during the discard overrides fetch_pc/skip_lo. The discard still applies.
  - No fetch issues in the cycle BR_TAKEN is high.
- Unaligned target (bit1=1): the first word pushes only its upper halfword, which needs only 1 slot. The issue check still requires 2 slots.

Decomposition:
- Shared package: FSM state encoding (IDLE/REQ/GAP), halfword width 16, word step 4.
- Sub-module: fetch_hw_fifo, a parameterised DEPTH x 48-bit queue ({pc,halfword}) with push0/push1 dual-push, pop, clear, count.
- FSM and address logic stay in thumb_fetch_unit.

Test Plan:
- Reset release, RESET_PC=0, INST_READY=1, memory returns 0xBBBB_AAAA at 0 and 0xDDDD_CCCC at 4:
  - IREQ=1 with IADDR=0 for cycles 0-1, IREQ=0 in cycle 2.
  - INST=0xAAAA PC=0 in cycle 3, then 0xBBBB PC=2, then 0xCCCC PC=4 / 0xDDDD PC=6.
- INST_READY=0, DEPTH=4: exactly 2 words fetched; count=4; IREQ stays 0 until a pop frees 2 slots.
- BR_TAKEN with BR_TARGET=0x102 during REQ:
  - In-flight data discarded; FLUSHING=1 for the remaining window.
  - Next IADDR=0x100; only the upper halfword is presented, with INST_PC=0x102.
- BR_TAKEN in the same cycle as a pop and a capture push: the popped instruction counts as delivered, the pushed halfwords are absent, and the queue is empty next cycle.
- fetch_pc=0xFFFF_FFFC: the fetch pushes PCs 0xFFFF_FFFC/0xFFFF_FFFE, and the next IADDR is 0x0000_0000.
- RESET_N asserted mid-REQ: IREQ=0 and INST_VALID=0 immediately (async). After release, fetch restarts at RESET_PC.
